memory_nrw_masked: RTL and testbench

Parametrised multi-port synchronous RAM with per-port read/write, byte-lane write masks, defined same-cycle collision rules and an optional output register stage. It is the next generation of the team's fixed 2-port 32x64 read/write memory, used for register files and small scratchpads in the core. It adds a read-valid pulse, held read data and a write-conflict flag.

---
 rtl/memory_nrw_masked.sv | 130 +++++++++++++
 tb/tb_memory_nrw_masked.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_nrw_masked.sv
// Multi-port synchronous RAM with byte-lane write masks, fixed
// collision priority, optional same-cycle bypass and output register.
module memory_nrw_masked #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int PORTS      = 2,
  parameter bit OUT_REG    = 1'b0,
  parameter bit BYPASS     = 1'b1,
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [PORTS-1:0]                 en,
  input  logic [PORTS-1:0]                 we,
  input  logic [PORTS*ADDR_WIDTH-1:0]      addr,
  input  logic [PORTS*DATA_WIDTH-1:0]      wdata,
  input  logic [PORTS*MASK_WIDTH-1:0]      wmask,
  output logic [PORTS*DATA_WIDTH-1:0]      rdata,
  output logic [PORTS-1:0]                 rvalid,
  output logic                             conflict
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] a  [PORTS];
  logic [DATA_WIDTH-1:0] wd [PORTS];
  logic [MASK_WIDTH-1:0] wm [PORTS];
  logic [PORTS-1:0]      is_wr;
  logic [PORTS-1:0]      is_rd;
  logic [DATA_WIDTH-1:0] rd_word [PORTS];
  logic                  conflict_d;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      a[p]     = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      wd[p]    = wdata[p*DATA_WIDTH +: DATA_WIDTH];
      wm[p]    = wmask[p*MASK_WIDTH +: MASK_WIDTH];
      is_wr[p] = en[p] & we[p];
      is_rd[p] = en[p] & ~we[p];
    end
  end

  // Bypass replays this cycle's writes in port order, so the
  // read sees exactly the word the array holds after the edge.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      rd_word[p] = mem[a[p]];
      if (BYPASS) begin
        for (int q = 0; q < PORTS; q++) begin
          for (int b = 0; b < MASK_WIDTH; b++) begin
            if (is_wr[q] && a[q] == a[p] && wm[q][b])
              rd_word[p][8*b +: 8] = wd[q][8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = p + 1; q < PORTS; q++) begin
        if (is_wr[p] && is_wr[q] && a[p] == a[q] &&
            |(wm[p] & wm[q]))
          conflict_d = 1'b1;
      end
    end
  end

  // Later ports overwrite earlier ones on shared lanes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int q = 0; q < PORTS; q++) begin
        for (int b = 0; b < MASK_WIDTH; b++) begin
          if (is_wr[q] && wm[q][b])
            mem[a[q]][8*b +: 8] <= wd[q][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      conflict <= 1'b0;
    else
      conflict <= conflict_d;
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic                  vo;
    logic [DATA_WIDTH-1:0] dq;

    if (OUT_REG) begin : g_oreg
      logic                  v1;
      logic [DATA_WIDTH-1:0] d1;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          v1 <= 1'b0;
          d1 <= '0;
          vo <= 1'b0;
          dq <= '0;
        end else begin
          v1 <= is_rd[p];
          if (is_rd[p])
            d1 <= rd_word[p];
          vo <= v1;
          if (v1)
            dq <= d1;
        end
      end
    end else begin : g_nreg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vo <= 1'b0;
          dq <= '0;
        end else begin
          vo <= is_rd[p];
          if (is_rd[p])
            dq <= rd_word[p];
        end
      end
    end

    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = dq;
    assign rvalid[p] = vo;
  end

endmodule

// File: tb/tb_memory_nrw_masked.sv
// Bench for memory_nrw_masked: three configurations share one stimulus
// stream and are checked against a word-level model every cycle.
module tb_memory_nrw_masked;

  logic         clock;
  logic         reset;
  logic [1:0]   en, we;
  logic [4:0]   ta [2];
  logic [63:0]  td [2];
  logic [7:0]   tm [2];
  logic [9:0]   addr;
  logic [127:0] wdata;
  logic [15:0]  wmask;

  logic [127:0] rdq [3];
  logic [1:0]   rvq [3];
  logic         cfq [3];

  assign addr  = {ta[1], ta[0]};
  assign wdata = {td[1], td[0]};
  assign wmask = {tm[1], tm[0]};

  memory_nrw_masked #(.OUT_REG(1'b0), .BYPASS(1'b1)) u_d0 (
    .clock(clock), .reset(reset), .en(en), .we(we), .addr(addr),
    .wdata(wdata), .wmask(wmask), .rdata(rdq[0]), .rvalid(rvq[0]),
    .conflict(cfq[0]));

  memory_nrw_masked #(.OUT_REG(1'b0), .BYPASS(1'b0)) u_d1 (
    .clock(clock), .reset(reset), .en(en), .we(we), .addr(addr),
    .wdata(wdata), .wmask(wmask), .rdata(rdq[1]), .rvalid(rvq[1]),
    .conflict(cfq[1]));

  memory_nrw_masked #(.OUT_REG(1'b1), .BYPASS(1'b1)) u_d2 (
    .clock(clock), .reset(reset), .en(en), .we(we), .addr(addr),
    .wdata(wdata), .wmask(wmask), .rdata(rdq[2]), .rvalid(rvq[2]),
    .conflict(cfq[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // model: word array plus per-config delivery slots indexed by cycle
  logic [63:0] mm [32];
  logic        sv [3][2][8];
  logic [63:0] sd [3][2][8];
  logic [63:0] held [3][2];
  logic        exp_cf;
  int          lat [3] = '{0, 0, 1};
  bit          byp [3] = '{1'b1, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mclear();
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        held[k][p] = '0;
        for (int s = 0; s < 8; s++) begin
          sv[k][p][s] = 1'b0;
          sd[k][p][s] = '0;
        end
      end
    exp_cf = 1'b0;
  endtask

  task automatic idle();
    en = '0;
    we = '0;
    for (int p = 0; p < 2; p++) begin
      ta[p] = '0;
      td[p] = '0;
      tm[p] = '0;
    end
  endtask

  task automatic wr(input int p, input logic [4:0] a,
                    input logic [63:0] d, input logic [7:0] m);
    en[p] = 1'b1;
    we[p] = 1'b1;
    ta[p] = a;
    td[p] = d;
    tm[p] = m;
  endtask

  task automatic rdp(input int p, input logic [4:0] a);
    en[p] = 1'b1;
    we[p] = 1'b0;
    ta[p] = a;
    tm[p] = '0;
  endtask

  task automatic tick();
    logic [63:0] pre [2];
    logic [63:0] post [2];
    logic [63:0] v;
    logic        ev;
    int          s;
    @(posedge clock);
    cyc++;
    if (reset) begin
      mclear();
    end else begin
      for (int p = 0; p < 2; p++)
        pre[p] = mm[ta[p]];
      exp_cf = en[0] && we[0] && en[1] && we[1] &&
               ta[0] == ta[1] && (tm[0] & tm[1]) != 8'h00;
      for (int p = 0; p < 2; p++)
        if (en[p] && we[p])
          for (int b = 0; b < 8; b++)
            if (tm[p][b])
              mm[ta[p]][8*b +: 8] = td[p][8*b +: 8];
      for (int p = 0; p < 2; p++)
        post[p] = mm[ta[p]];
      for (int k = 0; k < 3; k++)
        for (int p = 0; p < 2; p++)
          if (en[p] && !we[p]) begin
            s = (cyc + lat[k]) % 8;
            sv[k][p][s] = 1'b1;
            sd[k][p][s] = byp[k] ? post[p] : pre[p];
          end
    end
    #2;
    s = cyc % 8;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        ev = sv[k][p][s];
        if (ev) begin
          held[k][p] = sd[k][p][s];
          sv[k][p][s] = 1'b0;
        end
        v = rdq[k][p*64 +: 64];
        chk($sformatf("c%0d rdata d%0d p%0d", cyc, k, p), v, held[k][p]);
        chk($sformatf("c%0d rvalid d%0d p%0d", cyc, k, p),
            {63'b0, rvq[k][p]}, {63'b0, ev});
      end
      chk($sformatf("c%0d conflict d%0d", cyc, k),
          {63'b0, cfq[k]}, {63'b0, exp_cf});
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    mclear();
    for (int i = 0; i < 32; i++)
      mm[i] = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset rdata", rdq[0][63:0], 64'h0);
    chk("reset rvalid", {62'b0, rvq[2]}, 64'h0);

    // basic write then cross-port read
    wr(0, 5'd3, 64'h0123456789ABCDEF, 8'hFF);
    tick();
    idle();
    rdp(1, 5'd3);
    tick();
    chk("basic rdata p1", rdq[0][127:64], 64'h0123456789ABCDEF);
    chk("basic rvalid p1", {63'b0, rvq[0][1]}, 64'h1);
    chk("basic rdata p0", rdq[0][63:0], 64'h0);
    idle();
    tick();
    chk("basic outreg p1", rdq[2][127:64], 64'h0123456789ABCDEF);

    // byte mask
    wr(0, 5'd7, 64'h1111111111111111, 8'hFF);
    tick();
    idle();
    wr(1, 5'd7, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    tick();
    idle();
    rdp(0, 5'd7);
    tick();
    chk("mask rdata", rdq[0][63:0], 64'h11111111FFFFFFFF);
    idle();
    tick();

    // overlapping write collision
    wr(0, 5'd9, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    wr(1, 5'd9, 64'h5555555555555555, 8'hF0);
    tick();
    chk("collide conflict", {63'b0, cfq[0]}, 64'h1);
    idle();
    rdp(0, 5'd9);
    tick();
    chk("collide conflict drop", {63'b0, cfq[0]}, 64'h0);
    chk("collide rdata", rdq[0][63:0], 64'h55555555AAAAAAAA);
    idle();
    tick();

    // disjoint lanes, same address: both land, no conflict
    wr(0, 5'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    wr(1, 5'd5, 64'hBBBBBBBBBBBBBBBB, 8'hF0);
    tick();
    chk("disjoint conflict", {63'b0, cfq[0]}, 64'h0);
    idle();
    rdp(0, 5'd5);
    rdp(1, 5'd5);
    tick();
    chk("disjoint rdata", rdq[0][63:0], 64'hBBBBBBBBAAAAAAAA);
    idle();
    tick();

    // bypass versus old data
    wr(0, 5'd2, 64'h0, 8'hFF);
    tick();
    idle();
    wr(0, 5'd2, 64'hDEAD, 8'hFF);
    rdp(1, 5'd2);
    tick();
    chk("bypass1", rdq[0][127:64], 64'hDEAD);
    chk("bypass0", rdq[1][127:64], 64'h0);
    idle();
    rdp(0, 5'd2);
    tick();
    chk("bypass outreg", rdq[2][127:64], 64'hDEAD);
    chk("after write", rdq[1][63:0], 64'hDEAD);
    idle();
    tick();

    // streaming reads
    for (int i = 0; i < 3; i++) begin
      idle();
      wr(0, 5'(i), 64'(10 + i), 8'hFF);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 3)
        rdp(0, 5'(i));
      tick();
      if (i == 0)
        chk("stream d0 first", rdq[0][63:0], 64'd10);
      if (i == 1) begin
        chk("stream d2 rvalid", {63'b0, rvq[2][0]}, 64'h1);
        chk("stream d2 first", rdq[2][63:0], 64'd10);
      end
      if (i == 4) begin
        chk("stream d2 held", rdq[2][63:0], 64'd12);
        chk("stream d2 idle", {63'b0, rvq[2][0]}, 64'h0);
      end
    end

    // reset in the middle of a read
    idle();
    rdp(0, 5'd3);
    tick();
    idle();
    #1 reset = 1'b1;
    mclear();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async rst rdata d%0d", k), rdq[k][63:0], 64'h0);
      chk($sformatf("async rst rvalid d%0d", k), {62'b0, rvq[k]}, 64'h0);
    end
    #3 reset = 1'b0;
    tick();
    chk("post rst d2 rvalid", {63'b0, rvq[2][0]}, 64'h0);
    chk("post rst d2 rdata", rdq[2][63:0], 64'h0);
    rdp(0, 5'd3);
    tick();
    idle();
    tick();
    chk("reread d2", rdq[2][63:0], 64'h0123456789ABCDEF);

    // top-of-range addresses, alternating collisions and reads
    for (int i = 0; i < 8; i++) begin
      idle();
      wr(0, 5'(31 - i), 64'h0101010101010101 * 64'(i + 1), 8'hFF);
      if (i % 2 == 1)
        wr(1, 5'(31 - i), ~(64'h0303030303030303 * 64'(i)), 8'h3C);
      else if (i > 0)
        rdp(1, 5'(32 - i));
      else
        rdp(1, 5'd3);
      tick();
    end
    idle();
    rdp(0, 5'd31);
    rdp(1, 5'd24);
    tick();
    chk("addr31", rdq[0][63:0], 64'h0101010101010101);
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
